branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
Control-hazard controller for the 5-stage pipeline. It predicts conditional branches in ID using a table of 2-bit saturating counters (BHT) indexed by PC, and redirects immediately on jumps and predicted-taken branches. It tracks each ID prediction into EX, compares it with the ALU outcome, and issues a PC redirect plus IF/ID and ID/EXE flushes on a mispredict. It also trains the BHT. It sits beside the branch unit, consumes its branch_pc and jump_pc, and drives the PC mux select.

Parameters:
DATA_W, 32, PC and target width
BHT_IDX_W, 4, log2 of BHT entries (16); index = pc[BHT_IDX_W+1:2]

Ports:
clk  in  1  clock
arst_n  in  1  async active-low reset
enable  in  1  pipeline advance; 0 = stall
id_valid  in  1  ID holds a real instruction
id_branch  in  1  ID instruction is a conditional branch
id_jump  in  1  ID instruction is an unconditional jump
id_pc  in  DATA_W  PC of ID instruction
id_updated_pc  in  DATA_W  id_pc+4
id_branch_pc  in  DATA_W  branch target from branch unit
id_jump_pc  in  DATA_W  jump target from branch unit
ex_taken  in  1  resolved condition of EX instruction (ALU zero/compare)
pc_redirect  out  1  PC mux takes next_pc this cycle
next_pc  out  DATA_W  redirect target
flush_if_id  out  1  squash IF/ID register
flush_id_exe  out  1  squash ID/EXE register
pred_taken  out  1  ID-stage prediction (for debug/trace)

Behaviour:
- Reset is asynchronous and active-low on arst_n, clocked by clk. On reset all BHT entries = 2'b01 (weakly not-taken) and the EX tracking register is invalid. While arst_n = 0, all outputs are 0.
- BHT read is combinational at id_pc index. pred_taken = id_valid & id_branch & bht[idx][1].
- EX tracking register: {valid, branch, pred, idx, fallthrough = id_updated_pc, target = id_branch_pc}.
  - Loads from ID on every clk edge with enable = 1.
  - valid loads 0 if flush_id_exe is asserted that cycle.
  - Holds when enable = 0.
- Mispredict: ex.valid & ex.branch & (ex_taken != ex.pred).
- Output priority, evaluated only when enable = 1; with enable = 0 all redirect/flush outputs are 0:
  1. Mispredict: pc_redirect = 1, flush_if_id = 1, flush_id_exe = 1, next_pc = ex_taken ? ex.target : ex.fallthrough.
  2. Otherwise, ID jump (id_valid & id_jump): pc_redirect = 1, flush_if_id = 1, next_pc = id_jump_pc.
  3. Otherwise, pred_taken: pc_redirect = 1, flush_if_id = 1, next_pc = id_branch_pc.
  4. Otherwise, all 0 and next_pc = id_updated_pc.
- An EX mispredict overrides any ID redirect in the same cycle. The ID instruction is squashed and is not loaded into the EX register.
- Training: on a clk edge with enable = 1 and ex.valid & ex.branch, bht[ex.idx] increments if ex_taken, else decrements.
  - Saturates at 2'b11 and 2'b00.
  - Training happens exactly once per resolved branch; a stall does not repeat it.
- Same-index ID read and EX write in one cycle: ID sees the pre-update value (no bypass).
- Latency: ID redirect costs 1 bubble; mispredict costs 2 bubbles.
- Reset asserted mid-operation clears the BHT and the tracking register immediately; any pending redirect is lost.

Optional Feature:
BRANCH_STATS_EN. When defined, three extra outputs are added: stat_branches, stat_mispredicts, stat_jumps (32-bit each).
- They count resolved branches, mispredicts and ID jumps on enable = 1 edges.
- They wrap at 2^32 and reset to 0.
When undefined, the outputs and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package branch_pkg: BHT counter localparams (SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11), the reset value WNT, and the EX tracking-register struct/field widths.
- One natural sub-module: sat_counter2, the 2-bit saturating update, instantiated once on the write path.

Test Plan:
- Reset, then ID branch at pc 0x40 with target 0x80 -> pred_taken = 0, no redirect. EX ex_taken = 1 -> redirect, next_pc = 0x80, both flushes, bht[0] = 2'b10.
- Same branch resolved taken 3 times -> bht[0] saturates at 2'b11. Next ID hit gives pred_taken = 1, redirect to 0x80, flush_if_id only.
- Predicted-taken branch resolves not-taken -> next_pc = 0x44, both flushes, counter 11 -> 10.
- ID jump (id_jump_pc = 0x100) in the same cycle as an EX mispredict -> next_pc = EX value, and the jump is not tracked on the next cycle.
- enable = 0 for 3 cycles during EX resolution -> no redirect, no BHT change. Redirect and a single update occur on the first enable = 1 cycle.
- arst_n pulsed low mid-stream -> outputs 0 immediately, all BHT entries read WNT afterwards. With BRANCH_STATS_EN, all stat counters read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared BHT counter encodings and EX tracking-register layout
package branch_pkg;

  localparam int PC_W  = 32;
  localparam int IDX_W = 4;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BHT_RST = WNT;

  typedef struct packed {
    logic             valid;
    logic             branch;
    logic             pred;
    logic [IDX_W-1:0] idx;
    logic [PC_W-1:0]  fallthrough;
    logic [PC_W-1:0]  target;
  } ex_reg_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter update
module sat_counter2
  import branch_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       up,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cnt;
    if (up) begin
      if (cnt != ST) nxt = cnt + 2'b01;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - BHT branch predictor and control-hazard redirect/flush
// Defining BRANCH_STATS_EN adds branch/mispredict/jump event counters.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int DATA_W    = PC_W,
  parameter int BHT_IDX_W = IDX_W
)(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_updated_pc,
  input  logic [DATA_W-1:0] id_branch_pc,
  input  logic [DATA_W-1:0] id_jump_pc,
  input  logic              ex_taken,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] next_pc,
  output logic              flush_if_id,
  output logic              flush_id_exe,
  output logic              pred_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts,
  output logic [31:0]       stat_jumps
`endif
);

  logic [1:0]           bht [2**BHT_IDX_W];
  ex_reg_t              ex;
  logic [BHT_IDX_W-1:0] id_idx;
  logic                 pred;
  logic                 mispredict;
  logic                 train;
  logic [1:0]           bht_next;
  logic                 unused_pc_bits;

  assign id_idx         = id_pc[BHT_IDX_W+1:2];
  assign unused_pc_bits = ^{id_pc[DATA_W-1:BHT_IDX_W+2], id_pc[1:0]};

  assign pred       = id_valid & id_branch & bht[id_idx][1];
  assign mispredict = ex.valid & ex.branch & (ex_taken != ex.pred);
  assign train      = enable & ex.valid & ex.branch;
  assign pred_taken = pred & arst_n;

  sat_counter2 u_sat (
    .cnt (bht[ex.idx]),
    .up  (ex_taken),
    .nxt (bht_next)
  );

  // EX mispredict outranks any ID redirect; everything is forced low while in reset.
  always_comb begin
    pc_redirect  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    next_pc      = id_updated_pc;
    if (enable) begin
      if (mispredict) begin
        pc_redirect  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
        next_pc      = ex_taken ? ex.target : ex.fallthrough;
      end else if (id_valid & id_jump) begin
        pc_redirect = 1'b1;
        flush_if_id = 1'b1;
        next_pc     = id_jump_pc;
      end else if (pred) begin
        pc_redirect = 1'b1;
        flush_if_id = 1'b1;
        next_pc     = id_branch_pc;
      end
    end
    if (!arst_n) begin
      pc_redirect  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_exe = 1'b0;
      next_pc      = '0;
    end
  end

  // Training is tied to the EX register advancing, so a stall cannot train twice.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= BHT_RST;
    end else if (train) begin
      bht[ex.idx] <= bht_next;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex <= '0;
    end else if (enable) begin
      ex.valid       <= id_valid & ~mispredict;
      ex.branch      <= id_branch;
      ex.pred        <= pred;
      ex.idx         <= id_idx;
      ex.fallthrough <= id_updated_pc;
      ex.target      <= id_branch_pc;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_jumps       <= '0;
    end else if (enable) begin
      if (train) stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      if (id_valid & id_jump) stat_jumps <= stat_jumps + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed and randomized checks of branch_ctrl against a prediction model
module tb_branch_ctrl;

  logic        clk;
  logic        arst_n;
  logic        enable;
  logic        id_valid;
  logic        id_branch;
  logic        id_jump;
  logic [31:0] id_pc;
  logic [31:0] id_updated_pc;
  logic [31:0] id_branch_pc;
  logic [31:0] id_jump_pc;
  logic        ex_taken;
  logic        pc_redirect;
  logic [31:0] next_pc;
  logic        flush_if_id;
  logic        flush_id_exe;
  logic        pred_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  logic [31:0] stat_jumps;
`endif

  branch_ctrl dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .enable        (enable),
    .id_valid      (id_valid),
    .id_branch     (id_branch),
    .id_jump       (id_jump),
    .id_pc         (id_pc),
    .id_updated_pc (id_updated_pc),
    .id_branch_pc  (id_branch_pc),
    .id_jump_pc    (id_jump_pc),
    .ex_taken      (ex_taken),
    .pc_redirect   (pc_redirect),
    .next_pc       (next_pc),
    .flush_if_id   (flush_if_id),
    .flush_id_exe  (flush_id_exe),
    .pred_taken    (pred_taken)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .stat_jumps       (stat_jumps)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a counter per table slot plus the (at most one) instruction sitting in EX.
  typedef struct {
    bit          br;
    bit          pred;
    int          idx;
    logic [31:0] ft;
    logic [31:0] tgt;
  } inst_t;

  int    bht_m [16];
  inst_t inflight [$];
  int    checks;
  int    failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    inflight.delete();
  endtask

  task automatic check_bht(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, 32'(dut.bht[i]), 32'(bht_m[i]));
  endtask

  task automatic step(input bit en, input bit v, input bit br, input bit jp,
                      input logic [31:0] pc, input logic [31:0] bpc,
                      input logic [31:0] jpc, input bit tk);
    int          idx;
    bit          exp_pred, has_br, misp, e_red, e_fif, e_fie;
    logic [31:0] e_npc;
    inst_t       n;
    @(negedge clk);
    enable = en; id_valid = v; id_branch = br; id_jump = jp;
    id_pc = pc; id_updated_pc = pc + 32'd4; id_branch_pc = bpc; id_jump_pc = jpc;
    ex_taken = tk;
    #1;
    idx      = int'((pc >> 2) % 16);
    exp_pred = v && br && (bht_m[idx] >= 2);
    has_br   = (inflight.size() > 0) && inflight[0].br;
    misp     = has_br && (tk != inflight[0].pred);
    e_red = 0; e_fif = 0; e_fie = 0; e_npc = pc + 32'd4;
    if (en) begin
      if (misp) begin
        e_red = 1; e_fif = 1; e_fie = 1;
        e_npc = tk ? inflight[0].tgt : inflight[0].ft;
      end else if (v && jp) begin
        e_red = 1; e_fif = 1; e_npc = jpc;
      end else if (exp_pred) begin
        e_red = 1; e_fif = 1; e_npc = bpc;
      end
    end
    chk("pred_taken",   32'(pred_taken),   32'(exp_pred));
    chk("pc_redirect",  32'(pc_redirect),  32'(e_red));
    chk("flush_if_id",  32'(flush_if_id),  32'(e_fif));
    chk("flush_id_exe", 32'(flush_id_exe), 32'(e_fie));
    chk("next_pc",      next_pc,           e_npc);
    if (en) begin
      if (has_br) begin
        if (tk) bht_m[inflight[0].idx] = (bht_m[inflight[0].idx] == 3) ? 3 : bht_m[inflight[0].idx] + 1;
        else    bht_m[inflight[0].idx] = (bht_m[inflight[0].idx] == 0) ? 0 : bht_m[inflight[0].idx] - 1;
      end
      inflight.delete();
      if (v && !misp) begin
        n.br = br; n.pred = exp_pred; n.idx = idx; n.ft = pc + 32'd4; n.tgt = bpc;
        inflight.push_back(n);
      end
    end
  endtask

  task automatic rand_step();
    bit          en, v, br, jp, tk;
    logic [31:0] pc;
    int          kind;
    en   = ($urandom_range(0, 9) < 8);
    v    = ($urandom_range(0, 9) < 8);
    kind = $urandom_range(0, 9);
    br   = (kind < 6);
    jp   = (kind >= 8);
    tk   = $urandom_range(0, 1);
    pc   = 32'h0000_1000 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) << 6);
    step(en, v, br, jp, pc, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, tk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    // Reset with a live jump on the inputs: outputs must still be held at 0.
    arst_n = 1'b0; enable = 1'b1; id_valid = 1'b1; id_branch = 1'b0; id_jump = 1'b1;
    id_pc = 32'h40; id_updated_pc = 32'h44; id_branch_pc = 32'h80; id_jump_pc = 32'h100;
    ex_taken = 1'b0;
    #12;
    chk("rst_redirect", 32'(pc_redirect), 32'd0);
    chk("rst_next_pc", next_pc, 32'd0);
    chk("rst_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("rst_flush_id_exe", 32'(flush_id_exe), 32'd0);
    chk("rst_pred", 32'(pred_taken), 32'd0);
    check_bht("rst_bht");
    @(negedge clk);
    arst_n = 1'b1;

    // Not-taken prediction, resolved taken: mispredict to target, counter 01 -> 10.
    step(1, 1, 1, 0, 32'h40, 32'h80, 32'h0, 0);
    step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 1);
    @(posedge clk); #1;
    chk("bht0_after_first", 32'(dut.bht[0]), 32'h2);

    // Three more taken resolutions saturate at 11.
    repeat (3) begin
      step(1, 1, 1, 0, 32'h40, 32'h80, 32'h0, 0);
      step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 1);
    end
    @(posedge clk); #1;
    chk("bht0_saturated", 32'(dut.bht[0]), 32'h3);

    // Predicted-taken hit, then resolved not-taken: fall back to 0x44, 11 -> 10.
    step(1, 1, 1, 0, 32'h40, 32'h80, 32'h0, 0);
    step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    chk("bht0_after_nt", 32'(dut.bht[0]), 32'h2);

    // ID jump collides with EX mispredict: EX wins and the jump is not tracked.
    step(1, 1, 1, 0, 32'h40, 32'h80, 32'h0, 0);
    step(1, 1, 0, 1, 32'h50, 32'h0, 32'h100, 0);
    @(posedge clk); #1;
    chk("jump_not_tracked", 32'(dut.ex.valid), 32'd0);
    step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 1);

    // Stall across resolution: no redirect, no training until enable returns.
    step(1, 1, 1, 0, 32'h40, 32'h80, 32'h0, 0);
    repeat (3) step(0, 1, 0, 1, 32'h60, 32'h0, 32'h300, 1);
    check_bht("bht_during_stall");
    step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 1);
    step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 1);
    check_bht("bht_after_stall");

    // Randomized traffic over a few colliding indices.
    for (int i = 0; i < 400; i++) begin
      rand_step();
      if (i % 50 == 49) check_bht("bht_random");
    end

    // Reset pulse mid-stream with a jump presented in ID.
    @(negedge clk);
    enable = 1'b1; id_valid = 1'b1; id_branch = 1'b0; id_jump = 1'b1; id_jump_pc = 32'h100;
    #2;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_redirect", 32'(pc_redirect), 32'd0);
    chk("mid_rst_next_pc", next_pc, 32'd0);
    chk("mid_rst_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("mid_rst_flush_id_exe", 32'(flush_id_exe), 32'd0);
    chk("mid_rst_ex_valid", 32'(dut.ex.valid), 32'd0);
    model_reset();
    check_bht("mid_rst_bht");
`ifdef BRANCH_STATS_EN
    chk("mid_rst_stat_branches", stat_branches, 32'd0);
    chk("mid_rst_stat_mispredicts", stat_mispredicts, 32'd0);
    chk("mid_rst_stat_jumps", stat_jumps, 32'd0);
`endif
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 100; i++) rand_step();
    check_bht("bht_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
